// File: rtl/nibble_packer.sv
// nibble_packer: packs four consecutive Johnson-step nibbles (LSB first)
// into a 16-bit word and queues completed words in a first-word-fall-through
// FIFO with a valid/ready output. Illegal counter codes and dropped words
// raise sticky flags.
// Optional feature: define NIBBLE_PACKER_PARITY_EN to add the word_par
// output, an even-parity bit computed at push and stored per FIFO entry.
module nibble_packer #(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic [3:0]              jcnt_in,
    input  logic [3:0]              nib_in,
    input  logic                    flush,
    input  logic                    word_ready,
    output logic [15:0]             word_out,
    output logic                    word_valid,
    output logic [$clog2(DEPTH):0]  fifo_level,
    output logic [1:0]              nib_cnt,
    output logic                    overflow,
    output logic                    phase_err
`ifdef NIBBLE_PACKER_PARITY_EN
    ,
    output logic                    word_par
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    logic [3:0]    jcnt_q;
    logic [1:0]    nibCnt_q, nibCnt_d;
    logic [11:0]   pack_q, pack_d;
    logic [AW-1:0] rdPtr_q, wrPtr_q;
    logic [AW:0]   level_q, level_d;
    logic          overflow_q, phaseErr_q;
    logic [15:0]   mem [DEPTH];

    logic          jcntLegal, strobe, wordDone, flushPush, push;
    logic [15:0]   asmWord;
    logic          full, empty, pop, accept, drop;

    // Decode the eight legal Johnson counter codes
    always_comb begin
        jcntLegal = 1'b0;
        case (jcnt_in)
            4'b0000, 4'b1000, 4'b1100, 4'b1110,
            4'b1111, 4'b0111, 4'b0011, 4'b0001: jcntLegal = 1'b1;
            default:                            jcntLegal = 1'b0;
        endcase
    end

    assign strobe = jcntLegal && (jcnt_in != jcnt_q);

    // Assemble the word to push (strobe nibble merged in) and next pack state
    always_comb begin
        asmWord = {4'h0, pack_q};
        if (strobe) begin
            case (nibCnt_q)
                2'd0:    asmWord[3:0]   = nib_in;
                2'd1:    asmWord[7:4]   = nib_in;
                2'd2:    asmWord[11:8]  = nib_in;
                default: asmWord[15:12] = nib_in;
            endcase
        end
        wordDone  = strobe && (nibCnt_q == 2'd3);
        flushPush = flush && ((nibCnt_q != 2'd0) || strobe);
        push      = wordDone || flushPush;
        nibCnt_d  = nibCnt_q;
        pack_d    = pack_q;
        if (push) begin
            nibCnt_d = 2'd0;
            pack_d   = 12'h000;
        end else if (strobe) begin
            nibCnt_d = nibCnt_q + 2'd1;
            pack_d   = asmWord[11:0];
        end
    end

    assign full   = (level_q == FULL_LEVEL);
    assign empty  = (level_q == '0);
    assign pop    = !empty && word_ready;
    assign accept = push && (!full || pop);
    assign drop   = push && full && !pop;

    // FIFO occupancy: a simultaneous push and pop leaves the level unchanged
    always_comb begin
        level_d = level_q;
        case ({accept, pop})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase
    end

    // Control state: counter copy, pack register, FIFO pointers, sticky flags
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            jcnt_q     <= 4'b0000;
            nibCnt_q   <= 2'd0;
            pack_q     <= 12'h000;
            rdPtr_q    <= '0;
            wrPtr_q    <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            phaseErr_q <= 1'b0;
        end else begin
            jcnt_q   <= jcnt_in;
            nibCnt_q <= nibCnt_d;
            pack_q   <= pack_d;
            level_q  <= level_d;
            if (accept) wrPtr_q <= wrPtr_q + AW'(1);
            if (pop)    rdPtr_q <= rdPtr_q + AW'(1);
            if (drop)       overflow_q <= 1'b1;
            if (!jcntLegal) phaseErr_q <= 1'b1;
        end
    end

    // Word storage needs no reset: empty pointers mask stale contents
    always_ff @(posedge clk) begin
        if (accept) mem[wrPtr_q] <= asmWord;
    end

`ifdef NIBBLE_PACKER_PARITY_EN
    logic parMem [DEPTH];

    // Parity is computed once at push and travels with its word
    always_ff @(posedge clk) begin
        if (accept) parMem[wrPtr_q] <= ^asmWord;
    end

    assign word_par = empty ? 1'b0 : parMem[rdPtr_q];
`endif

    assign word_out   = empty ? 16'h0000 : mem[rdPtr_q];
    assign word_valid = !empty;
    assign fifo_level = level_q;
    assign nib_cnt    = nibCnt_q;
    assign overflow   = overflow_q;
    assign phase_err  = phaseErr_q;

endmodule

// File: tb/tb_nibble_packer.sv
// tb_nibble_packer: directed stimulus for nibble_packer with a word
// scoreboard; expected words are queued as stimulus is driven and checked
// when the DUT hands a word over (word_valid && word_ready).
module tb_nibble_packer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic [3:0]  jcnt_in = 4'b0000;
    logic [3:0]  nib_in = 4'h0;
    logic        flush = 1'b0;
    logic        word_ready = 1'b0;
    logic [15:0] word_out;
    logic        word_valid;
    logic [$clog2(DEPTH):0] fifo_level;
    logic [1:0]  nib_cnt;
    logic        overflow;
    logic        phase_err;
`ifdef NIBBLE_PACKER_PARITY_EN
    logic        word_par;
`endif

    int checks = 0;
    int errors = 0;
    logic [15:0] sb[$];
    logic [3:0]  jseq [8] = '{4'b0000, 4'b1000, 4'b1100, 4'b1110,
                             4'b1111, 4'b0111, 4'b0011, 4'b0001};
    int jIdx = 0;

    nibble_packer #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .jcnt_in    (jcnt_in),
        .nib_in     (nib_in),
        .flush      (flush),
        .word_ready (word_ready),
        .word_out   (word_out),
        .word_valid (word_valid),
        .fifo_level (fifo_level),
        .nib_cnt    (nib_cnt),
        .overflow   (overflow),
        .phase_err  (phase_err)
`ifdef NIBBLE_PACKER_PARITY_EN
        ,
        .word_par   (word_par)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: sample handshake mid-cycle, then advance to just after the edge
    task automatic tick();
        logic [15:0] expWord;
        #3;
        if (word_valid && word_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("[TB] FAIL unexpected_word: observed %h expected none", word_out);
            end else begin
                expWord = sb.pop_front();
                check("word_out", 32'(word_out), 32'(expWord));
`ifdef NIBBLE_PACKER_PARITY_EN
                check("word_par", 32'(word_par), 32'(^expWord));
`endif
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic [3:0] nib, input logic fl, input logic rdy);
        jIdx       = (jIdx + 1) % 8;
        jcnt_in    = jseq[jIdx];
        nib_in     = nib;
        flush      = fl;
        word_ready = rdy;
        tick();
    endtask

    task automatic idle(input logic fl, input logic rdy);
        flush      = fl;
        word_ready = rdy;
        tick();
    endtask

    task automatic sendWord(input int base, input logic rdyLast, input logic expectIt);
        logic [15:0] w;
        logic [3:0]  n;
        w = 16'h0000;
        for (int k = 0; k < 4; k++) begin
            n = 4'((base + k + 1) % 16);
            w[4*k +: 4] = n;
        end
        if (expectIt) sb.push_back(w);
        for (int k = 0; k < 4; k++) begin
            step(w[4*k +: 4], 1'b0, (k == 3) ? rdyLast : 1'b0);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_valid", 32'(word_valid), 32'd0);
        check("rst_word", 32'(word_out), 32'h0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_phase_err", 32'(phase_err), 32'd0);
        n_rst = 1'b1;
        idle(1'b0, 1'b1);
        check("release_nib_cnt", 32'(nib_cnt), 32'd0);
        check("release_valid", 32'(word_valid), 32'd0);

        // Full word 4321, one clock latency from the 4th step
        step(4'h1, 1'b0, 1'b1);
        step(4'h2, 1'b0, 1'b1);
        step(4'h3, 1'b0, 1'b1);
        check("pre_word_nib_cnt", 32'(nib_cnt), 32'd3);
        check("pre_word_valid", 32'(word_valid), 32'd0);
        sb.push_back(16'h4321);
        step(4'h4, 1'b0, 1'b1);
        check("word_latency_valid", 32'(word_valid), 32'd1);
        check("word_nib_cnt", 32'(nib_cnt), 32'd0);
        idle(1'b0, 1'b1);
        check("after_pop_valid", 32'(word_valid), 32'd0);

        // Partial word flushed with zero padding
        step(4'hA, 1'b0, 1'b0);
        step(4'hB, 1'b0, 1'b0);
        check("partial_nib_cnt", 32'(nib_cnt), 32'd2);
        sb.push_back(16'h00BA);
        idle(1'b1, 1'b0);
        check("flush_nib_cnt", 32'(nib_cnt), 32'd0);
        check("flush_level", 32'(fifo_level), 32'd1);
        check("flush_head", 32'(word_out), 32'h00BA);
        idle(1'b0, 1'b1);

        // Flush coinciding with word completion pushes exactly once
        step(4'hC, 1'b0, 1'b0);
        step(4'hD, 1'b0, 1'b0);
        step(4'hE, 1'b0, 1'b0);
        sb.push_back(16'hFEDC);
        step(4'hF, 1'b1, 1'b0);
        check("flush_done_level", 32'(fifo_level), 32'd1);
        check("flush_done_nib_cnt", 32'(nib_cnt), 32'd0);
        idle(1'b0, 1'b1);
        idle(1'b1, 1'b0);
        check("empty_flush_level", 32'(fifo_level), 32'd0);
        check("empty_flush_valid", 32'(word_valid), 32'd0);

        // Illegal code mid-word
        step(4'h5, 1'b0, 1'b1);
        check("pre_illegal_phase_err", 32'(phase_err), 32'd0);
        jcnt_in = 4'b1010;
        nib_in  = 4'h9;
        tick();
        check("illegal_phase_err", 32'(phase_err), 32'd1);
        check("illegal_nib_cnt", 32'(nib_cnt), 32'd1);
        step(4'h6, 1'b0, 1'b1);
        check("post_illegal_nib_cnt", 32'(nib_cnt), 32'd2);
        step(4'h7, 1'b0, 1'b1);
        sb.push_back(16'h8765);
        step(4'h8, 1'b0, 1'b1);
        idle(1'b0, 1'b1);

        // Overflow: five words with no ready, fifth is dropped
        for (int i = 0; i < 5; i++) begin
            sendWord(i * 4, 1'b0, i < 4);
            if (i == 3) begin
                check("full_level", 32'(fifo_level), 32'd4);
                check("full_overflow", 32'(overflow), 32'd0);
            end
        end
        check("ovf_level", 32'(fifo_level), 32'd4);
        check("ovf_flag", 32'(overflow), 32'd1);
        repeat (6) idle(1'b0, 1'b1);
        check("drain_level", 32'(fifo_level), 32'd0);
        check("drain_word", 32'(word_out), 32'h0);
        check("drain_sb", 32'(sb.size()), 32'd0);
        check("overflow_sticky", 32'(overflow), 32'd1);

        // Reset mid-fill discards FIFO contents and partial word
        for (int i = 0; i < 4; i++) sendWord(i + 7, 1'b0, 1'b0);
        step(4'h1, 1'b0, 1'b0);
        step(4'h2, 1'b0, 1'b0);
        n_rst = 1'b0;
        #1;
        check("mid_rst_level", 32'(fifo_level), 32'd0);
        check("mid_rst_valid", 32'(word_valid), 32'd0);
        check("mid_rst_nib_cnt", 32'(nib_cnt), 32'd0);
        check("mid_rst_overflow", 32'(overflow), 32'd0);
        check("mid_rst_phase_err", 32'(phase_err), 32'd0);
        jIdx    = 0;
        jcnt_in = 4'b0000;
        idle(1'b0, 1'b0);
        idle(1'b0, 1'b0);
        n_rst = 1'b1;
        idle(1'b0, 1'b0);
        check("rerelease_nib_cnt", 32'(nib_cnt), 32'd0);

        // Full FIFO with pop on the completing cycle: no drop
        for (int i = 0; i < 4; i++) sendWord(i * 3 + 2, 1'b0, 1'b1);
        sendWord(11, 1'b1, 1'b1);
        check("full_pop_overflow", 32'(overflow), 32'd0);
        check("full_pop_level", 32'(fifo_level), 32'd4);
        repeat (6) idle(1'b0, 1'b1);
        check("final_level", 32'(fifo_level), 32'd0);
        check("final_sb", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nibble_packer.md
# nibble_packer

Downstream consumer of the Johnson-phase data latch. It samples the latched 4-bit data once per Johnson-counter step and packs four consecutive nibbles, LSB first, into a 16-bit word. Completed words go into a first-word-fall-through (FWFT) FIFO with a valid/ready output handshake. The block also flags illegal counter codes and FIFO overflow.

## Interface
- DEPTH, 4, FIFO depth in words; power of two, >= 2
- clk  in  1  clock, rising edge
- n_rst  in  1  reset, asynchronous, active-low
- jcnt_in  in  4  Johnson counter state from the latch stage
- nib_in  in  4  latched data nibble from the latch stage
- flush  in  1  synchronous; emit partial word
- word_ready  in  1  downstream accepts word this cycle
- word_out  out  16  FIFO head word; 16'h0000 when empty
- word_valid  out  1  FIFO not empty
- fifo_level  out  $clog2(DEPTH)+1  words stored
- nib_cnt  out  2  nibbles held in the pack register
- overflow  out  1  sticky; a word was dropped
- phase_err  out  1  sticky; an illegal jcnt_in code was seen

## Operation
- Legal jcnt_in codes: 0000, 1000, 1100, 1110, 1111, 0111, 0011, 0001.
- jcnt_q is a registered copy of jcnt_in, loaded every cycle.
- Strobe is asserted when jcnt_in != jcnt_q and jcnt_in is legal.
- On an illegal jcnt_in: phase_err sets, no capture happens, and jcnt_q still updates.
- On strobe: nib_in is written to pack[4*nib_cnt +: 4], then nib_cnt increments.
- When the 4th nibble is captured (nib_cnt == 3 on strobe):
  - the word {nib_in, pack[11:0]} is pushed;
  - nib_cnt wraps to 0;
  - the pack register is cleared.
- Flush with nib_cnt > 0, or with a strobe in the same cycle:
  - the strobe's nibble is included first;
  - the partial word is pushed with zero padding in the upper nibbles;
  - nib_cnt becomes 0.
- Flush with nib_cnt == 0 and no strobe: no action.
- If the strobe completes a word in the same cycle as flush, exactly one push occurs.
- Pop happens when word_valid && word_ready.
- Push when full:
  - with a simultaneous pop, the push is accepted and the level is unchanged;
  - otherwise the word is dropped and overflow sets.
- Push and pop in the same cycle with the FIFO not full: level is unchanged and order is preserved.
- Sticky flags clear only on reset.

## Timing
- Reset values:
  - jcnt_q = 0000, which matches the counter's reset value, so there is no capture on release;
  - nib_cnt = 0, pack = 0;
  - fifo_level = 0, word_valid = 0, word_out = 0;
  - overflow = 0, phase_err = 0.
- Strobe is combinational, in the same cycle jcnt_in changes.
- Capture and push happen on the rising edge that ends the strobe cycle.
- A completed word appears on word_out with word_valid = 1 directly after that edge (latency 1 clock from the 4th strobe).
- word_out and word_valid are FWFT, so the head word is visible without a pop.
- After a pop, the next word shows after the same edge.
- Reset asserted mid-word or mid-drain:
  - all state clears immediately;
  - partial words and FIFO contents are discarded.
- Free-running counter (one step per clk): one word every 4 cycles. A sustained rate needs word_ready high for at least 1 in 4 cycles.

## Configuration
- NIBBLE_PACKER_PARITY_EN defined:
  - adds output word_par (1 bit), the even parity (XOR) of word_out;
  - parity is computed at push and stored per FIFO entry;
  - word_par is 0 when empty.
- Not defined: the word_par port and its storage are absent; all other behaviour is identical.

## Test plan
- Reset release with jcnt_in = 0000 -> no strobe, nib_cnt = 0, word_valid = 0.
- Counter walks 1000, 1100, 1110, 1111 with nib_in = 1, 2, 3, 4, word_ready = 1 -> word_out = 16'h4321, word_valid for 1 cycle, 1 clock after the 4th step. With parity enabled: word_par = 1.
- Two nibbles A, B then flush -> word_out = 16'h00BA, nib_cnt = 0.
- jcnt_in = 1010 for 1 cycle mid-word -> phase_err = 1, nib_cnt unchanged, next legal step captures normally.
- word_ready = 0, DEPTH = 4, 5 words produced -> fifo_level = 4, overflow = 1. Drain yields the first four words in order; the 5th is lost.
- Full FIFO, 5th word completes while word_ready = 1 -> overflow stays 0, fifo_level stays 4, the 5th word is delivered after the 4th.
